// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and constants for the instruction-memory loader
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // Length header is always four bytes, LSB first, whatever the word size.
    localparam int LEN_BYTES = 4;
    // Payload checksum is a plain modulo-256 byte sum.
    localparam int CSUM_W    = 8;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs consecutive bytes into one memory word
//
// Ports:
//   clk, resetb        clock, asynchronous active-low reset
//   clear              drop any partial word and restart at lane 0
//   byte_en            a byte is being consumed this cycle
//   byte_data          the byte being consumed
//   word               partial word with byte_data already merged in (combinational),
//                      so the caller can register it on the edge of the last byte
//   last               the byte at byte_data completes the current word
module word_assembler #(
    parameter int WORD_BYTES = 4,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    clear,
    input  logic                    byte_en,
    input  logic [7:0]              byte_data,
    output logic [8*WORD_BYTES-1:0] word,
    output logic                    last
);

    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

    logic [LANE_W-1:0]       lane;
    logic [LANE_W-1:0]       pos;
    logic [8*WORD_BYTES-1:0] partial;

    // The first byte of a word lands in the LSB lane for little-endian
    // and in the MSB lane for big-endian.
    always_comb begin
        pos  = BIG_ENDIAN ? (LAST_LANE - lane) : lane;
        word = partial;
        word[8*pos +: 8] = byte_data;
    end

    assign last = (lane == LAST_LANE);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            lane    <= '0;
            partial <= '0;
        end else if (clear) begin
            lane    <= '0;
            partial <= '0;
        end else if (byte_en) begin
            if (last) begin
                lane    <= '0;
                partial <= '0;
            end else begin
                lane    <= lane + LANE_W'(1);
                partial <= word;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed, checksummed byte stream into instruction memory
//
// Ports:
//   clk, resetb         clock, asynchronous active-low reset
//   start               begin a new load session (honoured in IDLE, DONE, ERR)
//   s_valid, s_data     incoming byte stream
//   s_ready             stream ready (high while receiving LEN, DATA or CSUM)
//   mem_we, mem_addr,   one-cycle word write into instruction memory
//   mem_wdata
//   core_resetb         releases the core only after a successful load
//   busy, done, error   registered session status
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int WORD_BYTES = 4,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    start,
    input  logic                    s_valid,
    input  logic [7:0]              s_data,
    output logic                    s_ready,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    core_resetb,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int WORD_W = 8 * WORD_BYTES;

    state_t              state, next_state;
    logic [31:0]         len_word;
    logic [1:0]          len_cnt;
    logic [ADDR_W:0]     word_idx;   // one extra bit so a full-depth count fits
    logic [ADDR_W:0]     n_words;
    logic [CSUM_W-1:0]   csum;

    logic                accept;
    logic                start_ok;
    logic [31:0]         len_full;
    logic                len_last;
    logic                len_too_big;
    logic [WORD_W-1:0]   asm_word;
    logic                asm_last;
    logic                word_done;
    logic                last_word;

    assign s_ready   = busy;
    assign accept    = s_valid && s_ready;
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    // Length arrives LSB first: shifting right leaves the complete count once the 4th byte lands.
    assign len_full  = {s_data, len_word[31:8]};
    assign len_last  = (len_cnt == 2'(LEN_BYTES - 1));
    assign len_too_big = ({1'b0, len_full} > (33'd1 << ADDR_W));
    assign word_done = accept && (state == ST_DATA) && asm_last;
    assign last_word = ((word_idx + (ADDR_W+1)'(1)) == n_words);

    word_assembler #(
        .WORD_BYTES (WORD_BYTES),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_asm (
        .clk       (clk),
        .resetb    (resetb),
        .clear     (start_ok),
        .byte_en   (accept && (state == ST_DATA)),
        .byte_data (s_data),
        .word      (asm_word),
        .last      (asm_last)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) next_state = ST_LEN;
            end
            ST_LEN: begin
                if (accept && len_last) begin
                    if (len_too_big)        next_state = ST_ERR;
                    else if (len_full == 0) next_state = ST_CSUM;
                    else                    next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_done && last_word) next_state = ST_CSUM;
            end
            ST_CSUM: begin
                if (accept) next_state = (s_data == csum) ? ST_DONE : ST_ERR;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Status outputs are registered from next_state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            core_resetb <= 1'b0;
        end else begin
            state       <= next_state;
            busy        <= (next_state == ST_LEN) || (next_state == ST_DATA) || (next_state == ST_CSUM);
            done        <= (next_state == ST_DONE);
            error       <= (next_state == ST_ERR);
            core_resetb <= (next_state == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            len_word  <= '0;
            len_cnt   <= '0;
            word_idx  <= '0;
            n_words   <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                len_word <= '0;
                len_cnt  <= '0;
                word_idx <= '0;
                n_words  <= '0;
                csum     <= '0;
            end else if (accept) begin
                case (state)
                    ST_LEN: begin
                        len_word <= len_full;
                        len_cnt  <= len_cnt + 2'd1;
                        if (len_last) n_words <= len_full[ADDR_W:0];
                    end
                    ST_DATA: begin
                        csum <= csum + s_data;
                        if (asm_last) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_idx[ADDR_W-1:0];
                            mem_wdata <= asm_word;
                            word_idx  <= word_idx + (ADDR_W+1)'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader (little- and big-endian instances)
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       resetb;
    logic       start;
    logic       s_valid;
    logic [7:0] s_data;

    logic        le_s_ready, le_mem_we, le_core_resetb, le_busy, le_done, le_error;
    logic [9:0]  le_mem_addr;
    logic [31:0] le_mem_wdata;
    logic        be_s_ready, be_mem_we, be_core_resetb, be_busy, be_done, be_error;
    logic [2:0]  be_mem_addr;
    logic [31:0] be_mem_wdata;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(10), .WORD_BYTES(4), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .resetb(resetb), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(le_s_ready), .mem_we(le_mem_we), .mem_addr(le_mem_addr), .mem_wdata(le_mem_wdata),
        .core_resetb(le_core_resetb), .busy(le_busy), .done(le_done), .error(le_error)
    );

    imem_loader #(.ADDR_W(3), .WORD_BYTES(4), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .resetb(resetb), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(be_s_ready), .mem_we(be_mem_we), .mem_addr(be_mem_addr), .mem_wdata(be_mem_wdata),
        .core_resetb(be_core_resetb), .busy(be_busy), .done(be_done), .error(be_error)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] le_wa[$], le_wd[$], be_wa[$], be_wd[$];
    logic [7:0]  pl[$];

    always @(negedge clk) begin
        if (le_mem_we) begin le_wa.push_back(32'(le_mem_addr)); le_wd.push_back(le_mem_wdata); end
        if (be_mem_we) begin be_wa.push_back(32'(be_mem_addr)); be_wd.push_back(be_mem_wdata); end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pl_sum(input int nbytes);
        logic [7:0] s = 8'd0;
        for (int i = 0; i < nbytes; i++) s = s + pl[i];
        return s;
    endfunction

    function automatic logic [31:0] exp_word(input int w, input bit be);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (be) v = (v << 8) | 32'(pl[w*4+k]);
            else    v = v | (32'(pl[w*4+k]) << (8*k));
        end
        return v;
    endfunction

    function automatic bit model_done(input logic [31:0] n, input int aw, input logic [7:0] cs);
        if ({32'd0, n} > (64'd1 << aw)) return 1'b0;
        return pl_sum(int'(n) * 4) == cs;
    endfunction

    task automatic check_dut(input string tag, input bit is_be, input logic [31:0] n, input bit exp_done);
        logic [31:0] wa[$], wd[$];
        int aw, nexp;
        logic [4:0] st;
        aw = is_be ? 3 : 10;
        if (is_be) begin
            wa = be_wa; wd = be_wd;
            st = {be_done, be_error, be_core_resetb, be_busy, be_s_ready};
        end else begin
            wa = le_wa; wd = le_wd;
            st = {le_done, le_error, le_core_resetb, le_busy, le_s_ready};
        end
        nexp = ({32'd0, n} > (64'd1 << aw)) ? 0 : int'(n);
        chk({tag, "_nwrites"}, 64'(wa.size()), 64'(nexp));
        for (int w = 0; w < nexp && w < wa.size(); w++) begin
            chk({tag, "_addr"}, 64'(wa[w]), 64'(w));
            chk({tag, "_data"}, 64'(wd[w]), 64'(exp_word(w, is_be)));
        end
        // done, error, core_resetb, busy, s_ready
        chk({tag, "_status"}, 64'(st), 64'({exp_done, !exp_done, exp_done, 1'b0, 1'b0}));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                s_data = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b1;
        s_data  = b;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic run_session(input logic [31:0] n, input int npay, input logic [7:0] cs,
                               input bit gaps, input bit junk_at_start, input bit start_mid);
        le_wa.delete(); le_wd.delete(); be_wa.delete(); be_wd.delete();
        start   = 1'b1;
        s_valid = junk_at_start;
        s_data  = 8'hA5;
        @(posedge clk); #1;
        start   = 1'b0;
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gaps);
        for (int i = 0; i < npay; i++) begin
            send_byte(pl[i], gaps);
            if (start_mid && i == 0) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        send_byte(cs, gaps);
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] n;
        bit          incr;
        bit          bad_cs;
        bit          gaps;
        bit          exp_le_done;
        bit          exp_be_done;
    } vec_t;

    vec_t vecs[8];
    logic [31:0] le_ref[3];
    logic [31:0] be_ref[3];

    initial begin
        int npay;
        logic [7:0] cs;
        logic [31:0] n;
        bit gaps, bad;

        vecs[0] = '{32'd3,    1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{32'd3,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'd1025, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{32'd3,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{32'd8,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{32'd9,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{32'd1,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        le_ref  = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
        be_ref  = '{32'h01020304, 32'h05060708, 32'h090A0B0C};

        resetb  = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("le_reset_outputs", {le_s_ready, le_mem_we, le_busy, le_done, le_error, le_core_resetb, 32'(le_mem_addr), le_mem_wdata}, 64'd0);
        chk("be_reset_outputs", {be_s_ready, be_mem_we, be_busy, be_done, be_error, be_core_resetb, 32'(be_mem_addr), be_mem_wdata}, 64'd0);
        resetb = 1'b1;

        // Stream bytes without start: the block must stay idle.
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
        @(negedge clk);
        chk("le_idle_until_start", {le_busy, le_s_ready, le_done, le_error, 32'(le_wa.size())}, 64'd0);
        chk("be_idle_until_start", {be_busy, be_s_ready, be_done, be_error, 32'(be_wa.size())}, 64'd0);
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            n = vecs[v].n;
            npay = (n > 32'd1024) ? 8 : int'(n) * 4;
            pl.delete();
            for (int i = 0; i < npay; i++) pl.push_back(vecs[v].incr ? 8'(i + 1) : 8'($urandom));
            cs = (n > 32'd1024) ? 8'h00 : pl_sum(npay) + 8'(vecs[v].bad_cs);
            run_session(n, npay, cs, vecs[v].gaps, 1'b0, 1'b0);
            check_dut($sformatf("vec%0d_le", v), 1'b0, n, vecs[v].exp_le_done);
            check_dut($sformatf("vec%0d_be", v), 1'b1, n, vecs[v].exp_be_done);
            if (v == 0) begin
                chk("vec0_csum_byte", 64'(cs), 64'h4E);
                for (int w = 0; w < 3; w++) begin
                    chk("vec0_le_ref_word", 64'(le_wd.size() > w ? le_wd[w] : 32'hDEAD_BEEF), 64'(le_ref[w]));
                    chk("vec0_be_ref_word", 64'(be_wd.size() > w ? be_wd[w] : 32'hDEAD_BEEF), 64'(be_ref[w]));
                end
            end
        end

        // start together with a valid byte must not consume it; start mid-session is ignored.
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        run_session(32'd2, 8, pl_sum(8), 1'b0, 1'b1, 1'b1);
        check_dut("start_junk_le", 1'b0, 32'd2, 1'b1);
        check_dut("start_junk_be", 1'b1, 32'd2, 1'b1);

        // Reset in the middle of a payload.
        le_wa.delete(); le_wd.delete(); be_wa.delete(); be_wd.delete();
        pl.delete();
        for (int i = 0; i < 12; i++) pl.push_back(8'($urandom) | 8'h01);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_byte(8'd3, 1'b0); send_byte(8'd0, 1'b0); send_byte(8'd0, 1'b0); send_byte(8'd0, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(pl[i], 1'b0);
        s_valid = 1'b1;
        s_data  = pl[5];
        #2;
        resetb = 1'b0;
        #1;
        chk("le_async_reset_outputs", {le_s_ready, le_mem_we, le_busy, le_done, le_error, le_core_resetb, 32'(le_mem_addr), le_mem_wdata}, 64'd0);
        chk("be_async_reset_outputs", {be_s_ready, be_mem_we, be_busy, be_done, be_error, be_core_resetb, 32'(be_mem_addr), be_mem_wdata}, 64'd0);
        for (int i = 5; i < 8; i++) send_byte(pl[i], 1'b0);
        resetb = 1'b1;
        for (int i = 8; i < 12; i++) send_byte(pl[i], 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("le_reset_abort_writes", 64'(le_wa.size()), 64'd1);
        chk("be_reset_abort_writes", 64'(be_wa.size()), 64'd1);
        chk("le_reset_word0", 64'(le_wd.size() > 0 ? le_wd[0] : 32'hDEAD_BEEF), 64'(exp_word(0, 1'b0)));
        chk("be_reset_word0", 64'(be_wd.size() > 0 ? be_wd[0] : 32'hDEAD_BEEF), 64'(exp_word(0, 1'b1)));
        chk("le_post_reset_idle", {le_busy, le_s_ready, le_done, le_error, le_core_resetb}, 64'd0);
        chk("be_post_reset_idle", {be_busy, be_s_ready, be_done, be_error, be_core_resetb}, 64'd0);
        @(posedge clk); #1;

        // Randomised sessions against the reference model.
        for (int r = 0; r < 14; r++) begin
            n = 32'($urandom_range(0, 9));
            npay = int'(n) * 4;
            pl.delete();
            for (int i = 0; i < npay; i++) pl.push_back(8'($urandom));
            bad  = ($urandom_range(0, 3) == 0);
            gaps = $urandom_range(0, 1) != 0;
            cs   = pl_sum(npay) + 8'(bad);
            run_session(n, npay, cs, gaps, $urandom_range(0, 1) != 0, 1'b0);
            check_dut($sformatf("rand%0d_le", r), 1'b0, n, model_done(n, 10, cs));
            check_dut($sformatf("rand%0d_be", r), 1'b1, n, model_done(n, 3, cs));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 10: word-address width; depth = 2**ADDR_W words.
REQ-002 Parameter WORD_BYTES, default 4: bytes per memory word; word width = 8*WORD_BYTES.
REQ-003 Parameter BIG_ENDIAN, default 0: 0 puts the first byte of each word in bits [7:0]; 1 puts it in the MSB byte.
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 resetb  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a load session.
REQ-007 s_valid  input  1  byte-stream valid.
REQ-008 s_data  input  8  byte-stream data.
REQ-009 s_ready  output  1  byte-stream ready.
REQ-010 mem_we  output  1  instruction-memory write strobe.
REQ-011 mem_addr  output  ADDR_W  instruction-memory word address.
REQ-012 mem_wdata  output  8*WORD_BYTES  instruction-memory write word.
REQ-013 core_resetb  output  1  active-low reset to the core.
REQ-014 busy, done, error  output  1 each  session status.

Function
REQ-015 The FSM SHALL have the states IDLE, LEN, DATA, CSUM, DONE and ERR, all registered.
REQ-016 A byte SHALL be accepted only on an edge where s_valid&&s_ready; s_ready SHALL be 1 in LEN, DATA and CSUM and 0 in all other states.
REQ-017 start SHALL move IDLE, DONE or ERR to LEN and clear the counters and checksum; start SHALL be ignored in LEN, DATA and CSUM.
REQ-018 LEN SHALL accept exactly 4 bytes forming a 32-bit word count N, least-significant byte first, independent of WORD_BYTES.
REQ-019 On the 4th length byte, N > 2**ADDR_W SHALL go to ERR, N == 0 SHALL go to CSUM, and otherwise SHALL go to DATA.
REQ-020 DATA SHALL assemble WORD_BYTES bytes per word using the byte order set by BIG_ENDIAN.
REQ-021 On the edge that accepts a word's last byte, the block SHALL register mem_we=1, mem_addr=word index and mem_wdata=assembled word, so the write is visible for exactly one cycle after that edge.
REQ-022 Word indices SHALL start at 0 and increment by 1; with N = 2**ADDR_W the last write SHALL be at 2**ADDR_W-1 with no wrap.
REQ-023 After word N the FSM SHALL go to CSUM.
REQ-024 The checksum SHALL be the 8-bit modulo-256 sum of all payload bytes; the length bytes are excluded.
REQ-025 In CSUM, one accepted byte equal to the checksum SHALL go to DONE, and any other value SHALL go to ERR.
REQ-026 The block SHALL sustain one byte per cycle with no bubbles, and SHALL tolerate any number of gaps in s_valid.
REQ-027 core_resetb SHALL be 1 only in DONE; it SHALL rise on the edge entering DONE and fall on the edge leaving it.
REQ-028 busy SHALL equal LEN|DATA|CSUM, done SHALL equal DONE, and error SHALL equal ERR; all three SHALL be registered.
REQ-029 If start and s_valid are both high in IDLE, DONE or ERR, that byte SHALL NOT be accepted.

Reset
REQ-030 While resetb=0 the block SHALL immediately force state=IDLE and all outputs to 0, including core_resetb, mem_addr and mem_wdata.
REQ-031 A reset during a session SHALL abort it with no further mem_we pulses; memory already written is undefined.
REQ-032 After resetb is released, the block SHALL remain in IDLE until start.

Structure
REQ-033 A shared package loader_pkg SHALL hold the state enumeration, LEN_BYTES=4 and CSUM_W=8.
REQ-034 Byte-lane assembly SHALL be the single sub-module word_assembler, parametrised by WORD_BYTES and BIG_ENDIAN.

Verification
REQ-035 Defaults; start; stream 03 00 00 00, bytes 01..0C, 4E -> writes 0:0x04030201, 1:0x08070605, 2:0x0C0B0A09; done=1, core_resetb=1.
REQ-036 BIG_ENDIAN=1, same stream -> writes 0:0x01020304, 1:0x05060708, 2:0x090A0B0C; done=1.
REQ-037 Same stream with checksum 4F -> error=1, core_resetb=0; a new start plus a correct stream -> done=1.
REQ-038 Length 01 04 00 00 (1025) with ADDR_W=10 -> ERR after the 4th byte, no mem_we, s_ready=0.
REQ-039 Length 0 then checksum 00 -> done=1, no mem_we; with random s_valid gaps on REQ-035 -> identical writes.
REQ-040 resetb pulsed low after 5 payload bytes -> all outputs 0 immediately, IDLE, no further writes.
